// File: rtl/ahb_mtx_pkg.sv
// ahb_mtx_pkg: shared AHB bus-matrix encodings and the held-burst substitution rule
// Contents: HTRANS, HBURST and HRESP encodings; held_burst() helper
package ahb_mtx_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // A held SEQ beat is replayed as a fresh NONSEQ; a fixed-length burst can no
    // longer be counted from here on, so it is downgraded to undefined-length INCR.
    function automatic logic [2:0] held_burst(input logic [1:0] trans, input logic [2:0] burst);
        return (trans == HTRANS_SEQ && burst != HBURST_SINGLE) ? HBURST_INCR : burst;
    endfunction

endpackage

// File: rtl/ahb_mtx_hold_reg.sv
// ahb_mtx_hold_reg: load-enabled address/control bank with pend/live output mux
// Ports: HCLK/HRESET clock and sync active-high reset; load captures the live
//        HxxxS controls; pend selects the held bank (NONSEQ/INCR substituted)
//        instead of the live controls on the *_ip outputs.
module ahb_mtx_hold_reg
    import ahb_mtx_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int USER_W = 4,
    parameter int MID_W  = 4
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              load,
    input  logic              pend,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [USER_W-1:0] HAUSERS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic [MID_W-1:0]  HMASTERS,
    input  logic              HMASTLOCKS,
    output logic              sel_ip,
    output logic [ADDR_W-1:0] addr_ip,
    output logic [USER_W-1:0] auser_ip,
    output logic [1:0]        trans_ip,
    output logic              write_ip,
    output logic [2:0]        size_ip,
    output logic [2:0]        burst_ip,
    output logic [3:0]        prot_ip,
    output logic [MID_W-1:0]  master_ip,
    output logic              mastlock_ip
);

    logic              sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [USER_W-1:0] auser_q;
    logic [1:0]        trans_q;
    logic              write_q;
    logic [2:0]        size_q;
    logic [2:0]        burst_q;
    logic [3:0]        prot_q;
    logic [MID_W-1:0]  master_q;
    logic              mastlock_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sel_q      <= 1'b0;
            addr_q     <= '0;
            auser_q    <= '0;
            trans_q    <= HTRANS_IDLE;
            write_q    <= 1'b0;
            size_q     <= '0;
            burst_q    <= HBURST_SINGLE;
            prot_q     <= '0;
            master_q   <= '0;
            mastlock_q <= 1'b0;
        end else if (load) begin
            sel_q      <= HSELS;
            addr_q     <= HADDRS;
            auser_q    <= HAUSERS;
            trans_q    <= HTRANSS;
            write_q    <= HWRITES;
            size_q     <= HSIZES;
            burst_q    <= HBURSTS;
            prot_q     <= HPROTS;
            master_q   <= HMASTERS;
            mastlock_q <= HMASTLOCKS;
        end
    end

    always_comb begin
        sel_ip      = pend ? sel_q                      : HSELS;
        addr_ip     = pend ? addr_q                     : HADDRS;
        auser_ip    = pend ? auser_q                    : HAUSERS;
        trans_ip    = pend ? HTRANS_NONSEQ              : HTRANSS;
        write_ip    = pend ? write_q                    : HWRITES;
        size_ip     = pend ? size_q                     : HSIZES;
        burst_ip    = pend ? held_burst(trans_q, burst_q) : HBURSTS;
        prot_ip     = pend ? prot_q                     : HPROTS;
        master_ip   = pend ? master_q                   : HMASTERS;
        mastlock_ip = pend ? mastlock_q                 : HMASTLOCKS;
    end

endmodule

// File: rtl/ahb_mtx_input_stage_hold.sv
// ahb_mtx_input_stage_hold: master-facing bus-matrix input stage that holds un-granted address phases
// Ports: HCLK/HRESET clock and sync active-high reset; HxxxS master address
//        phase and looped-back HREADYS; active_ip/readyout_ip/resp_ip from the
//        output stages; *_ip controls and held_tran_ip to the output stages;
//        HREADYOUTS/HRESPS back to the master.
module ahb_mtx_input_stage_hold
    import ahb_mtx_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int USER_W = 4,
    parameter int MID_W  = 4
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [USER_W-1:0] HAUSERS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic [MID_W-1:0]  HMASTERS,
    input  logic              HMASTLOCKS,
    input  logic              HREADYS,
    input  logic              active_ip,
    input  logic              readyout_ip,
    input  logic              resp_ip,
    output logic              sel_ip,
    output logic [ADDR_W-1:0] addr_ip,
    output logic [USER_W-1:0] auser_ip,
    output logic [1:0]        trans_ip,
    output logic              write_ip,
    output logic [2:0]        size_ip,
    output logic [2:0]        burst_ip,
    output logic [3:0]        prot_ip,
    output logic [MID_W-1:0]  master_ip,
    output logic              mastlock_ip,
    output logic              held_tran_ip,
    output logic              HREADYOUTS,
    output logic              HRESPS
);

    logic trans_valid;
    logic pend_tran;
    logic data_phase;
    logic take;

    assign trans_valid = HSELS & HREADYS & HTRANSS[1];
    // The held address is accepted by its output stage: leave pend and enter
    // the data phase on the same edge.
    assign take = pend_tran & active_ip & readyout_ip;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pend_tran  <= 1'b0;
            data_phase <= 1'b0;
        end else begin
            if (trans_valid & ~active_ip)
                pend_tran <= 1'b1;
            else if (take)
                pend_tran <= 1'b0;
            if (take)
                data_phase <= 1'b1;
            else if (HREADYS)
                data_phase <= trans_valid & active_ip;
        end
    end

    ahb_mtx_hold_reg #(
        .ADDR_W(ADDR_W),
        .USER_W(USER_W),
        .MID_W (MID_W)
    ) u_hold (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .load       (trans_valid),
        .pend       (pend_tran),
        .HSELS      (HSELS),
        .HADDRS     (HADDRS),
        .HAUSERS    (HAUSERS),
        .HTRANSS    (HTRANSS),
        .HWRITES    (HWRITES),
        .HSIZES     (HSIZES),
        .HBURSTS    (HBURSTS),
        .HPROTS     (HPROTS),
        .HMASTERS   (HMASTERS),
        .HMASTLOCKS (HMASTLOCKS),
        .sel_ip     (sel_ip),
        .addr_ip    (addr_ip),
        .auser_ip   (auser_ip),
        .trans_ip   (trans_ip),
        .write_ip   (write_ip),
        .size_ip    (size_ip),
        .burst_ip   (burst_ip),
        .prot_ip    (prot_ip),
        .master_ip  (master_ip),
        .mastlock_ip(mastlock_ip)
    );

    always_comb begin
        held_tran_ip = pend_tran | trans_valid;
        HREADYOUTS   = pend_tran ? 1'b0 : data_phase ? readyout_ip : 1'b1;
        HRESPS       = data_phase ? resp_ip : HRESP_OKAY;
    end

endmodule

// File: tb/tb_ahb_mtx_input_stage_hold.sv
// tb_ahb_mtx_input_stage_hold: directed and randomized checks of the input stage against a transaction model
module tb_ahb_mtx_input_stage_hold;

    typedef struct packed {
        logic        sel;
        logic [31:0] addr;
        logic [3:0]  auser;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic [3:0]  master;
        logic        mastlock;
    } ctl_t;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        hsels, hwrites, hmastlocks, hreadys;
    logic [31:0] haddrs;
    logic [3:0]  hausers, hprots, hmasters;
    logic [1:0]  htranss;
    logic [2:0]  hsizes, hbursts;
    logic        active_ip, readyout_ip, resp_ip;
    logic        sel_ip, write_ip, mastlock_ip, held_tran_ip, HREADYOUTS, HRESPS;
    logic [31:0] addr_ip;
    logic [3:0]  auser_ip, prot_ip, master_ip;
    logic [1:0]  trans_ip;
    logic [2:0]  size_ip, burst_ip;

    int n_cmp = 0;
    int n_err = 0;

    logic m_pend, m_dp;
    ctl_t m_held;

    always #5 HCLK = ~HCLK;
    // single master: the master's HREADY is this stage's own HREADYOUTS
    assign hreadys = HREADYOUTS;

    ahb_mtx_input_stage_hold dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .HSELS(hsels), .HADDRS(haddrs), .HAUSERS(hausers), .HTRANSS(htranss),
        .HWRITES(hwrites), .HSIZES(hsizes), .HBURSTS(hbursts), .HPROTS(hprots),
        .HMASTERS(hmasters), .HMASTLOCKS(hmastlocks), .HREADYS(hreadys),
        .active_ip(active_ip), .readyout_ip(readyout_ip), .resp_ip(resp_ip),
        .sel_ip(sel_ip), .addr_ip(addr_ip), .auser_ip(auser_ip), .trans_ip(trans_ip),
        .write_ip(write_ip), .size_ip(size_ip), .burst_ip(burst_ip), .prot_ip(prot_ip),
        .master_ip(master_ip), .mastlock_ip(mastlock_ip), .held_tran_ip(held_tran_ip),
        .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
    );

    function automatic ctl_t live_ctl();
        return '{hsels, haddrs, hausers, htranss, hwrites, hsizes, hbursts, hprots, hmasters, hmastlocks};
    endfunction

    function automatic ctl_t dut_ctl();
        return '{sel_ip, addr_ip, auser_ip, trans_ip, write_ip, size_ip, burst_ip, prot_ip, master_ip, mastlock_ip};
    endfunction

    function automatic logic e_ready();
        return m_pend ? 1'b0 : (m_dp ? readyout_ip : 1'b1);
    endfunction

    function automatic logic e_resp();
        return m_dp ? resp_ip : 1'b0;
    endfunction

    function automatic logic e_held_tran();
        return m_pend | (hsels & e_ready() & htranss[1]);
    endfunction

    function automatic ctl_t e_ctl();
        ctl_t c;
        if (!m_pend) return live_ctl();
        c = m_held;
        c.trans = 2'b10;
        if (m_held.trans == 2'b11 && m_held.burst != 3'b000) c.burst = 3'b001;
        return c;
    endfunction

    // advance one clock and update the transaction model with the pre-edge inputs
    task automatic tick();
        logic rdy, tv, take;
        ctl_t lv;
        rdy  = e_ready();
        tv   = hsels & rdy & htranss[1];
        take = m_pend & active_ip & readyout_ip;
        lv   = live_ctl();
        @(posedge HCLK);
        if (HRESET) begin
            m_pend = 1'b0;
            m_dp   = 1'b0;
            m_held = '0;
        end else begin
            if (tv & ~active_ip) m_pend = 1'b1;
            else if (take) m_pend = 1'b0;
            if (tv) m_held = lv;
            if (take) m_dp = 1'b1;
            else if (rdy) m_dp = tv & active_ip;
        end
        #1;
    endtask

    task automatic set_idle();
        hsels = 1'b0; haddrs = 32'hdead_beef; hausers = 4'h0; htranss = 2'b00;
        hwrites = 1'b0; hsizes = 3'd2; hbursts = 3'b000; hprots = 4'h3;
        hmasters = 4'h0; hmastlocks = 1'b0;
    endtask

    task automatic set_xfer(input logic [31:0] a, input logic [1:0] t, input logic w, input logic [2:0] b);
        hsels = 1'b1; haddrs = a; hausers = 4'h5; htranss = t; hwrites = w;
        hsizes = 3'd2; hbursts = b; hprots = 4'hb; hmasters = 4'h7; hmastlocks = 1'b1;
    endtask

    task automatic test_reset();
        HRESET = 1'b1; set_idle();
        active_ip = 1'b0; readyout_ip = 1'b1; resp_ip = 1'b0;
        tick(); tick();
        HRESET = 1'b0;
        @(negedge HCLK);
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", HREADYOUTS); end
        n_cmp++; if (HRESPS !== 1'b0) begin n_err++; $display("FAIL reset_resp: got %b want 0", HRESPS); end
        n_cmp++; if (held_tran_ip !== 1'b0) begin n_err++; $display("FAIL reset_held_tran: got %b want 0", held_tran_ip); end
        n_cmp++; if (addr_ip !== 32'hdead_beef) begin n_err++; $display("FAIL reset_addr_live: got %h want deadbeef", addr_ip); end
        tick();
    endtask

    task automatic test_granted();
        active_ip = 1'b1; readyout_ip = 1'b1;
        set_xfer(32'h0000_1000, 2'b10, 1'b1, 3'b000);
        @(negedge HCLK);
        n_cmp++; if (held_tran_ip !== 1'b1) begin n_err++; $display("FAIL grant_held_tran: got %b want 1", held_tran_ip); end
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL grant_addr_ready: got %b want 1", HREADYOUTS); end
        n_cmp++; if (addr_ip !== 32'h0000_1000) begin n_err++; $display("FAIL grant_addr: got %h want 00001000", addr_ip); end
        tick();
        set_idle(); readyout_ip = 1'b0;
        @(negedge HCLK);
        n_cmp++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL grant_dp_wait: got %b want 0", HREADYOUTS); end
        tick();
        readyout_ip = 1'b1;
        @(negedge HCLK);
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL grant_dp_done: got %b want 1", HREADYOUTS); end
        tick();
        readyout_ip = 1'b0;
        @(negedge HCLK);
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL grant_after_dp: got %b want 1", HREADYOUTS); end
        tick();
    endtask

    task automatic test_stall();
        active_ip = 1'b0; readyout_ip = 1'b1;
        set_xfer(32'h2000_0040, 2'b10, 1'b0, 3'b000);
        @(negedge HCLK);
        n_cmp++; if (held_tran_ip !== 1'b1) begin n_err++; $display("FAIL stall_req: got %b want 1", held_tran_ip); end
        tick();
        for (int i = 0; i < 3; i++) begin
            hsels = 1'($urandom); haddrs = $urandom; htranss = 2'($urandom); hbursts = 3'($urandom);
            @(negedge HCLK);
            n_cmp++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d]: got %b want 0", i, HREADYOUTS); end
            n_cmp++; if (addr_ip !== 32'h2000_0040) begin n_err++; $display("FAIL stall_addr[%0d]: got %h want 20000040", i, addr_ip); end
            n_cmp++; if (trans_ip !== 2'b10) begin n_err++; $display("FAIL stall_trans[%0d]: got %b want 10", i, trans_ip); end
            n_cmp++; if (held_tran_ip !== 1'b1) begin n_err++; $display("FAIL stall_held_tran[%0d]: got %b want 1", i, held_tran_ip); end
            tick();
        end
        active_ip = 1'b1; set_idle();
        @(negedge HCLK);
        n_cmp++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL stall_grant_cycle: got %b want 0", HREADYOUTS); end
        tick();
        @(negedge HCLK);
        n_cmp++; if (HREADYOUTS !== 1'b1 || trans_ip !== 2'b00) begin n_err++; $display("FAIL stall_released: got ready=%b trans=%b want ready=1 trans=00", HREADYOUTS, trans_ip); end
        tick();
    endtask

    task automatic test_seq_conv();
        active_ip = 1'b0; readyout_ip = 1'b1;
        set_xfer(32'h3000_0004, 2'b11, 1'b1, 3'b011);
        @(negedge HCLK);
        tick();
        set_idle();
        @(negedge HCLK);
        n_cmp++; if (trans_ip !== 2'b10) begin n_err++; $display("FAIL seq_trans: got %b want 10", trans_ip); end
        n_cmp++; if (burst_ip !== 3'b001) begin n_err++; $display("FAIL seq_burst: got %b want 001", burst_ip); end
        n_cmp++; if (mastlock_ip !== 1'b1) begin n_err++; $display("FAIL seq_lock_held: got %b want 1", mastlock_ip); end
        active_ip = 1'b1;
        tick(); tick();
    endtask

    task automatic test_error();
        active_ip = 1'b1; readyout_ip = 1'b1; resp_ip = 1'b0;
        set_xfer(32'h4000_0000, 2'b10, 1'b1, 3'b000);
        @(negedge HCLK);
        tick();
        set_idle(); resp_ip = 1'b1; readyout_ip = 1'b0;
        @(negedge HCLK);
        n_cmp++; if (HRESPS !== 1'b1 || HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL err_first: got resp=%b ready=%b want resp=1 ready=0", HRESPS, HREADYOUTS); end
        tick();
        readyout_ip = 1'b1;
        @(negedge HCLK);
        n_cmp++; if (HRESPS !== 1'b1 || HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL err_second: got resp=%b ready=%b want resp=1 ready=1", HRESPS, HREADYOUTS); end
        tick();
        @(negedge HCLK);
        n_cmp++; if (HRESPS !== 1'b0) begin n_err++; $display("FAIL err_after: got %b want 0", HRESPS); end
        resp_ip = 1'b0;
        tick();
    endtask

    task automatic test_idle();
        active_ip = 1'b0; readyout_ip = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_xfer($urandom, (i < 2) ? 2'b00 : 2'b01, 1'b0, 3'b000);
            if (i[0]) begin hsels = 1'b0; htranss = 2'b10; end
            @(negedge HCLK);
            n_cmp++; if (held_tran_ip !== 1'b0 || HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL idle[%0d]: got held_tran=%b ready=%b want 0/1", i, held_tran_ip, HREADYOUTS); end
            tick();
        end
    endtask

    task automatic test_reset_mid_pend();
        active_ip = 1'b0; readyout_ip = 1'b1;
        set_xfer(32'h5000_0010, 2'b10, 1'b0, 3'b000);
        @(negedge HCLK);
        tick();
        @(negedge HCLK);
        n_cmp++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL rmp_pending: got %b want 0", HREADYOUTS); end
        tick();
        HRESET = 1'b1; set_idle();
        tick();
        HRESET = 1'b0;
        @(negedge HCLK);
        n_cmp++; if (HREADYOUTS !== 1'b1 || HRESPS !== 1'b0 || held_tran_ip !== 1'b0) begin n_err++; $display("FAIL rmp_after: got ready=%b resp=%b held_tran=%b want 1/0/0", HREADYOUTS, HRESPS, held_tran_ip); end
        n_cmp++; if (trans_ip !== 2'b00) begin n_err++; $display("FAIL rmp_trans_live: got %b want 00", trans_ip); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            HRESET = ($urandom_range(0, 49) == 0);
            hsels = ($urandom_range(0, 3) != 0); haddrs = $urandom; hausers = 4'($urandom);
            htranss = 2'($urandom); hwrites = 1'($urandom); hsizes = 3'($urandom);
            hbursts = 3'($urandom); hprots = 4'($urandom); hmasters = 4'($urandom);
            hmastlocks = 1'($urandom);
            active_ip = ($urandom_range(0, 2) != 0); readyout_ip = ($urandom_range(0, 3) != 0);
            resp_ip = ($urandom_range(0, 7) == 0);
            @(negedge HCLK);
            n_cmp++; if (HREADYOUTS !== e_ready()) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, HREADYOUTS, e_ready()); end
            n_cmp++; if (HRESPS !== e_resp()) begin n_err++; $display("FAIL rnd_resp[%0d]: got %b want %b", i, HRESPS, e_resp()); end
            n_cmp++; if (held_tran_ip !== e_held_tran()) begin n_err++; $display("FAIL rnd_held_tran[%0d]: got %b want %b", i, held_tran_ip, e_held_tran()); end
            n_cmp++; if (dut_ctl() !== e_ctl()) begin n_err++; $display("FAIL rnd_ctl[%0d]: got %h want %h", i, dut_ctl(), e_ctl()); end
            tick();
        end
        HRESET = 1'b0;
    endtask

    initial begin
        m_pend = 1'b0; m_dp = 1'b0; m_held = '0;
        test_reset();
        test_granted();
        test_stall();
        test_seq_conv();
        test_error();
        test_idle();
        test_reset_mid_pend();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
